// File: rtl/id_decode_stage.sv
// ============================================================================
// Module   : id_decode_stage
// Brief    : Instruction-decode stage of the 16-bit, 8-register pipelined
//            processor. It decodes the register fields, extends the
//            immediate, holds the 8x16 register file with write-through,
//            selects the forwarded operands, and registers everything for
//            EX. The compare flags are derived from the registered operands.
// Options  : IDS_SIGNED_CMP_EN - when defined, A and B are compared as
//            two's-complement values. Otherwise they are compared unsigned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        WB_signals,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [4:0]  signals,
  input  logic [15:0] instruction,
  input  logic [15:0] NPC,
  input  logic [15:0] AluResult,
  input  logic [15:0] MemoryResult,
  input  logic [15:0] WBResult,
  input  logic [2:0]  RD4,
  output logic [15:0] I_TypeImmediate,
  output logic [15:0] J_TypeImmediate,
  output logic [15:0] ReturnAddress,
  output logic [15:0] PC1,
  output logic [15:0] Immediate1,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [2:0]  RD2,
  output logic [2:0]  RA,
  output logic [2:0]  RB,
  output logic        gt,
  output logic        lt,
  output logic        eq
);

  localparam logic [2:0] c_R0 = 3'd0;
  localparam logic [2:0] c_R7 = 3'd7;

  // Control bits of the decoded instruction
  logic w_src1, w_src2, w_regdst, w_extop, w_extplace;
  assign w_src1     = signals[4];
  assign w_src2     = signals[3];
  assign w_regdst   = signals[2];
  assign w_extop    = signals[1];
  assign w_extplace = signals[0];

  logic [2:0]  w_ra, w_rb, w_rd;
  logic [15:0] w_ext_imm;
  logic [15:0] w_reg_a, w_reg_b, w_reg_r7;
  logic [15:0] w_op_a, w_op_b;
  logic        w_wr_a, w_wr_b, w_wr_r7;

  logic [15:0] r_regs [8];

  logic [15:0] r_i_imm, r_j_imm, r_ret_addr, r_pc1, r_imm1, r_a, r_b;
  logic [2:0]  r_rd2, r_ra, r_rb;

  // Register-field selects
  assign w_ra = w_src1   ? c_R0 : instruction[8:6];
  assign w_rb = w_src2   ? instruction[5:3] : instruction[11:9];
  assign w_rd = w_regdst ? c_R7 : instruction[11:9];

  // Immediate extender: place in the upper byte, sign-extend, or zero-extend
  always_comb begin
    w_ext_imm = {8'h00, instruction[7:0]};
    if (w_extplace)
      w_ext_imm = {instruction[7:0], 8'h00};
    else if (w_extop)
      w_ext_imm = {{8{instruction[7]}}, instruction[7:0]};
  end

  // Write-through: a write this cycle is visible on the read ports right away
  assign w_wr_a  = WB_signals && (RD4 == w_ra);
  assign w_wr_b  = WB_signals && (RD4 == w_rb);
  assign w_wr_r7 = WB_signals && (RD4 == c_R7);

  assign w_reg_a  = w_wr_a  ? WBResult : r_regs[w_ra];
  assign w_reg_b  = w_wr_b  ? WBResult : r_regs[w_rb];
  assign w_reg_r7 = w_wr_r7 ? WBResult : r_regs[c_R7];

  // Operand A forwarding mux
  always_comb begin
    w_op_a = w_reg_a;
    case (ForwardA)
      2'd1:    w_op_a = AluResult;
      2'd2:    w_op_a = MemoryResult;
      2'd3:    w_op_a = WBResult;
      default: w_op_a = w_reg_a;
    endcase
  end

  // Operand B forwarding mux
  always_comb begin
    w_op_b = w_reg_b;
    case (ForwardB)
      2'd1:    w_op_b = AluResult;
      2'd2:    w_op_b = MemoryResult;
      2'd3:    w_op_b = WBResult;
      default: w_op_b = w_reg_b;
    endcase
  end

  // Register file: writes from WB are accepted even while the stage is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= 16'h0000;
    end else if (WB_signals) begin
      r_regs[RD4] <= WBResult;
    end
  end

  // ID/EX pipeline registers, which hold their values while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra       <= 3'd0;
      r_rb       <= 3'd0;
      r_rd2      <= 3'd0;
      r_a        <= 16'h0000;
      r_b        <= 16'h0000;
      r_imm1     <= 16'h0000;
      r_i_imm    <= 16'h0000;
      r_j_imm    <= 16'h0000;
      r_ret_addr <= 16'h0000;
      r_pc1      <= 16'h0000;
    end else if (!stall) begin
      r_ra       <= w_ra;
      r_rb       <= w_rb;
      r_rd2      <= w_rd;
      r_a        <= w_op_a;
      r_b        <= w_op_b;
      r_imm1     <= w_ext_imm;
      r_i_imm    <= w_ext_imm + NPC;
      r_j_imm    <= {NPC[15:12], instruction[11:0]};
      r_ret_addr <= w_reg_r7;
      r_pc1      <= NPC;
    end
  end

  assign RA              = r_ra;
  assign RB              = r_rb;
  assign RD2             = r_rd2;
  assign A               = r_a;
  assign B               = r_b;
  assign Immediate1      = r_imm1;
  assign I_TypeImmediate = r_i_imm;
  assign J_TypeImmediate = r_j_imm;
  assign ReturnAddress   = r_ret_addr;
  assign PC1             = r_pc1;

  // Compare flags on the registered operands; exactly one of them is set
  assign eq = (r_a == r_b);
`ifdef IDS_SIGNED_CMP_EN
  assign gt = ($signed(r_a) > $signed(r_b));
  assign lt = ($signed(r_a) < $signed(r_b));
`else
  assign gt = (r_a > r_b);
  assign lt = (r_a < r_b);
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_decode_stage.sv
// ============================================================================
// Module   : tb_id_decode_stage
// Brief    : Self-checking bench for id_decode_stage. It runs directed steps
//            followed by random cycles, and checks the outputs against a
//            behavioural model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        WB_signals = 1'b0;
  logic [1:0]  ForwardA = 2'd0;
  logic [1:0]  ForwardB = 2'd0;
  logic [4:0]  signals = 5'd0;
  logic [15:0] instruction = 16'h0;
  logic [15:0] NPC = 16'h0;
  logic [15:0] AluResult = 16'h0;
  logic [15:0] MemoryResult = 16'h0;
  logic [15:0] WBResult = 16'h0;
  logic [2:0]  RD4 = 3'd0;
  logic [15:0] I_TypeImmediate, J_TypeImmediate, ReturnAddress, PC1, Immediate1, A, B;
  logic [2:0]  RD2, RA, RB;
  logic        gt, lt, eq;

  int tests = 0;
  int fails = 0;

  // Model state: the architectural register file and the expected outputs
  logic [15:0] m_regs [8];
  logic [15:0] e_i_imm, e_j_imm, e_ret, e_pc1, e_imm1, e_a, e_b;
  logic [2:0]  e_rd2, e_ra, e_rb;

  id_decode_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .WB_signals(WB_signals),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .signals(signals),
    .instruction(instruction), .NPC(NPC), .AluResult(AluResult),
    .MemoryResult(MemoryResult), .WBResult(WBResult), .RD4(RD4),
    .I_TypeImmediate(I_TypeImmediate), .J_TypeImmediate(J_TypeImmediate),
    .ReturnAddress(ReturnAddress), .PC1(PC1), .Immediate1(Immediate1),
    .A(A), .B(B), .RD2(RD2), .RA(RA), .RB(RB), .gt(gt), .lt(lt), .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    e_i_imm = 0; e_j_imm = 0; e_ret = 0; e_pc1 = 0; e_imm1 = 0; e_a = 0; e_b = 0;
    e_rd2 = 0; e_ra = 0; e_rb = 0;
  endtask

  // A register read as the stage sees it: a write landing this cycle is visible
  function automatic logic [15:0] model_read(input int idx);
    if (WB_signals && int'(RD4) == idx) return WBResult;
    return m_regs[idx];
  endfunction

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] rf);
    case (sel)
      2'd0: return rf;
      2'd1: return AluResult;
      2'd2: return MemoryResult;
      default: return WBResult;
    endcase
  endfunction

  task automatic check_all();
    int ia, ib;
    chk("RA", {13'd0, RA}, {13'd0, e_ra});
    chk("RB", {13'd0, RB}, {13'd0, e_rb});
    chk("RD2", {13'd0, RD2}, {13'd0, e_rd2});
    chk("A", A, e_a);
    chk("B", B, e_b);
    chk("Immediate1", Immediate1, e_imm1);
    chk("I_TypeImmediate", I_TypeImmediate, e_i_imm);
    chk("J_TypeImmediate", J_TypeImmediate, e_j_imm);
    chk("ReturnAddress", ReturnAddress, e_ret);
    chk("PC1", PC1, e_pc1);
`ifdef IDS_SIGNED_CMP_EN
    ia = int'($signed(e_a)); ib = int'($signed(e_b));
`else
    ia = int'(e_a); ib = int'(e_b);
`endif
    chk("gt", {15'd0, gt}, {15'd0, ia > ib});
    chk("lt", {15'd0, lt}, {15'd0, ia < ib});
    chk("eq", {15'd0, eq}, {15'd0, ia == ib});
  endtask

  // One clock: predict from the current inputs, clock the DUT, then compare
  task automatic tick();
    int ra, rb, rd, imm8;
    logic [15:0] ext;
    ra   = signals[4] ? 0 : int'(instruction[8:6]);
    rb   = signals[3] ? int'(instruction[5:3]) : int'(instruction[11:9]);
    rd   = signals[2] ? 7 : int'(instruction[11:9]);
    imm8 = int'(instruction[7:0]);
    if (signals[0])                        ext = 16'(imm8 * 256);
    else if (signals[1] && imm8 >= 128)    ext = 16'(imm8 - 256);
    else                                   ext = 16'(imm8);
    @(posedge clk);
    if (!stall) begin
      e_ra = 3'(ra); e_rb = 3'(rb); e_rd2 = 3'(rd);
      e_a = pick(ForwardA, model_read(ra));
      e_b = pick(ForwardB, model_read(rb));
      e_imm1  = ext;
      e_i_imm = 16'((int'(ext) + int'(NPC)) % 65536);
      e_j_imm = 16'((int'(NPC) / 4096) * 4096 + int'(instruction) % 4096);
      e_ret   = model_read(7);
      e_pc1   = NPC;
    end
    if (WB_signals) m_regs[RD4] = WBResult;
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    #1 check_all();

    // Decode of a plain instruction with zero extension
    signals = 5'b00000; instruction = 16'h0323; NPC = 16'h0002;
    tick();
    chk("dec_RA", {13'd0, RA}, 16'd4);
    chk("dec_I", I_TypeImmediate, 16'h0025);
    chk("dec_J", J_TypeImmediate, 16'h0323);

    // Source selects, sign/zero extend and upper-byte placement
    signals = 5'b11010; instruction = 16'h0331; tick();
    chk("sel_RB", {13'd0, RB}, 16'd6);
    signals = 5'b00110; instruction = 16'h0080; tick();
    chk("sext_imm", Immediate1, 16'hFF80);
    chk("regdst_RD2", {13'd0, RD2}, 16'd7);
    signals = 5'b00001; tick();
    chk("place_imm", Immediate1, 16'h8000);

    // Register write, then a read of that register through ForwardA=0
    WB_signals = 1'b1; RD4 = 3'd3; WBResult = 16'h1234; signals = 5'b0; tick();
    WB_signals = 1'b0; instruction = 16'h00C0; tick();
    chk("rf_read_A", A, 16'h1234);

    // R7 write landing in the same cycle as the decode
    WB_signals = 1'b1; RD4 = 3'd7; WBResult = 16'h0042; tick();
    chk("r7_bypass", ReturnAddress, 16'h0042);
    WB_signals = 1'b0;

    // Forwarding sources
    ForwardA = 2'd1; AluResult = 16'h000A; ForwardB = 2'd2; MemoryResult = 16'h000C; tick();
    chk("fwd_alu", A, 16'h000A);
    chk("fwd_mem", B, 16'h000C);
    ForwardA = 2'd3; WBResult = 16'h000E; tick();
    chk("fwd_wb", A, 16'h000E);

    // Compare boundaries
    ForwardA = 2'd1; AluResult = 16'hFFFF; ForwardB = 2'd2; MemoryResult = 16'h0001; tick();
`ifdef IDS_SIGNED_CMP_EN
    chk("cmp_signed_lt", {15'd0, lt}, 16'd1);
`else
    chk("cmp_unsigned_gt", {15'd0, gt}, 16'd1);
`endif
    AluResult = 16'h0005; MemoryResult = 16'h0005; tick();
    chk("cmp_eq", {15'd0, eq}, 16'd1);

    // Stall holds the outputs but still lets a register write land
    stall = 1'b1; instruction = 16'hFFFF; NPC = 16'hABCD; signals = 5'b00011;
    WB_signals = 1'b1; RD4 = 3'd5; WBResult = 16'h5555; tick();
    chk("stall_PC1", PC1, 16'h0002);
    stall = 1'b0; WB_signals = 1'b0; ForwardA = 2'd0; signals = 5'b0;
    instruction = 16'h0140; tick();
    chk("stall_write", A, 16'h5555);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      stall        = ($urandom_range(0, 4) == 0);
      WB_signals   = $urandom_range(0, 1) == 1;
      ForwardA     = 2'($urandom_range(0, 3));
      ForwardB     = 2'($urandom_range(0, 3));
      signals      = 5'($urandom);
      instruction  = 16'($urandom);
      NPC          = 16'($urandom);
      AluResult    = 16'($urandom);
      MemoryResult = ($urandom_range(0, 3) == 0) ? AluResult : 16'($urandom);
      WBResult     = 16'($urandom);
      RD4          = 3'($urandom);
      tick();
    end

    // Asynchronous reset in the middle of the run
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    rst = 1'b0;
    stall = 1'b0; WB_signals = 1'b0; ForwardA = 2'd0; ForwardB = 2'd0;
    for (int r = 0; r < 8; r++) begin
      signals = 5'b00000;
      instruction = 16'(r * 64 + r * 512);
      tick();
      chk("post_rst_read", A, 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Instruction-decode pipeline stage of the 16-bit, 8-register pipelined processor.
- Decodes register-field selects and the destination register, and extends the 8-bit immediate (extender sub-block).
- Reads and writes an 8x16 register file sub-block and applies forwarding muxes to operands A/B.
- Produces branch/jump targets and compare flags (compare sub-block) registered for the EX stage.

Parameters:
- none (widths fixed: data 16, register index 3, immediate field 8)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  1 = hold all output registers
- WB_signals  in  1  register-file write enable from WB
- ForwardA  in  2  operand A select: 0 regfile, 1 AluResult, 2 MemoryResult, 3 WBResult
- ForwardB  in  2  operand B select, same encoding
- signals  in  5  [4] SRC1, [3] SRC2, [2] RegDst, [1] ExtOp, [0] ExtPlace
- instruction  in  16  instruction word in ID
- NPC  in  16  next PC of this instruction
- AluResult, MemoryResult, WBResult  in  16 each  forwarding sources; WBResult is also the write data
- RD4  in  3  write-back destination register
- I_TypeImmediate  out  16  ext_imm + NPC
- J_TypeImmediate  out  16  {NPC[15:12], instruction[11:0]}
- ReturnAddress  out  16  current R7 contents
- PC1  out  16  registered NPC
- Immediate1  out  16  registered ext_imm
- A, B  out  16 each  forwarded operands
- RD2, RA, RB  out  3 each  destination / source register indices
- gt, lt, eq  out  1 each  compare flags of A vs B

Behaviour:
Reset and stall:
- rst=1 (async): all output registers cleared to 0; all 8 registers cleared to 0.
- Flags after reset: eq=1, gt=0, lt=0.
- stall=1: every output register holds its value; register-file writes still occur.

Field decode (combinational from instruction):
- ra = SRC1 ? 0 : instruction[8:6]
- rb = SRC2 ? instruction[5:3] : instruction[11:9]
- rd = RegDst ? 7 : instruction[11:9]

Extender (combinational, in = instruction[7:0]):
- ExtPlace=1: ext_imm = {in, 8'h00}.
- ExtPlace=0, ExtOp=1: sign-extend in.
- ExtPlace=0, ExtOp=0: zero-extend in.

Register file:
- 8 x 16 bits; two async read ports (ra, rb) plus a dedicated R7 read.
- Write on rising clk when WB_signals=1: reg[RD4] <= WBResult.
- R0 is writable; reading index 0 returns stored contents.
- Write-through: a same-cycle write to ra, rb or R7 returns WBResult on the read.

Operand muxes:
- opA selected from {regA, AluResult, MemoryResult, WBResult} by ForwardA.
- opB selected likewise by ForwardB.

Pipeline registers (1-cycle latency, on rising clk when not stalled):
- RA<=ra, RB<=rb, RD2<=rd, A<=opA, B<=opB
- Immediate1<=ext_imm, I_TypeImmediate<=ext_imm+NPC (mod 2^16, carry dropped)
- J_TypeImmediate<={NPC[15:12], instruction[11:0]}, ReturnAddress<=R7, PC1<=NPC

Compare:
- Combinational on the registered A and B.
- Exactly one of gt, lt, eq is 1.
- Signedness is set by the optional feature below.

Optional Feature:
- IDS_SIGNED_CMP_EN defined: A and B compared as two's-complement signed.
- Not defined: compared as unsigned.
- No other behaviour changes.

Test Plan:
- Reset: rst pulse mid-simulation -> all outputs 0, eq=1; reading any register afterwards yields 0.
- Decode: signals=00000, instruction=0x0323, NPC=0x0002, clk -> RA=4, RB=1, RD2=1, Immediate1=0x0023, I_TypeImmediate=0x0025, J_TypeImmediate=0x0323, PC1=0x0002.
- Selects and extend: signals=11010, instruction=0x0331 -> RA=0, RB=6, RD2=1, Immediate1=0x0031; signals=00110, instruction=0x0080 -> RD2=7, Immediate1=0xFF80; signals=00001, instruction=0x0080 -> Immediate1=0x8000.
- Write/read/bypass: WB_signals=1, RD4=3, WBResult=0x1234, clk, then read ra=3 with ForwardA=0 -> A=0x1234. Writing R7=0x0042 in the same cycle as decode -> ReturnAddress=0x0042 (write-through).
- Forwarding: ForwardA=1 with AluResult=0x000A -> A=0x000A; ForwardB=2 with MemoryResult=0x000C -> B=0x000C; ForwardA=3 with WBResult=0x000E -> A=0x000E.
- Compare and stall:
  - A=0xFFFF, B=0x0001 -> signed build lt=1; unsigned build gt=1.
  - A=B=5 -> eq=1.
  - stall=1 with a new instruction -> all outputs unchanged.
